// File: rtl/ir_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : kfps2irkb_pkg
// Brief   : Shared types and defaults for the IR transmit scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package kfps2irkb_pkg;

  localparam int KEYCODE_W = 8;

  localparam logic [15:0] GAP_CYCLES_DEF    = 16'd44000;
  localparam logic [15:0] START_TIMEOUT_DEF = 16'd1000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } ir_sched_state_t;

  // Lone requester always wins; on contention the rr pointer picks.
  function automatic logic [1:0] rr_grant(input logic [1:0] valid, input logic rr);
    if (valid == 2'b11) begin
      return rr ? 2'b10 : 2'b01;
    end
    return valid;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ir_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : ir_tx_scheduler_if
// Brief   : Requester, serializer and status signals of the IR tx scheduler.
// Revision: 1.0 - initial release
// ============================================================================
interface ir_tx_scheduler_if #(
  parameter int FIFO_AW = 2
);
  import kfps2irkb_pkg::*;

  logic [1:0]           req_valid;
  logic [KEYCODE_W-1:0] req_code0;
  logic [KEYCODE_W-1:0] req_code1;
  logic [1:0]           req_ready;
  logic                 tx_start;
  logic [KEYCODE_W-1:0] tx_code;
  logic                 tx_busy;
  logic [FIFO_AW:0]     fifo_count;
  logic                 tx_timeout;
  logic                 clear_error;

  modport master (
    output req_valid, req_code0, req_code1, tx_busy, clear_error,
    input  req_ready, tx_start, tx_code, fifo_count, tx_timeout
  );

  modport slave (
    input  req_valid, req_code0, req_code1, tx_busy, clear_error,
    output req_ready, tx_start, tx_code, fifo_count, tx_timeout
  );
endinterface
`default_nettype wire

// File: rtl/ir_tx_scheduler_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ir_code_fifo
// Brief   : Small synchronous FIFO holding keycodes awaiting transmission.
// Revision: 1.0 - initial release
// ============================================================================
module ir_code_fifo #(
  parameter int FIFO_AW = 2,
  parameter int DW      = 8
) (
  input  wire logic              clock,
  input  wire logic              reset_n,
  input  wire logic              i_push,
  input  wire logic [DW-1:0]     i_din,
  input  wire logic              i_pop,
  output logic      [DW-1:0]     o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic      [FIFO_AW:0]  o_count
);
  localparam int               DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] C_DEPTH = DEPTH[FIFO_AW:0];

  logic [DW-1:0]      r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_count == C_DEPTH);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/ir_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : ir_tx_scheduler
// Brief   : Round-robin keycode arbiter, FIFO and launch/gap scheduler that
//           shares one IR serializer between two requesters.
// Revision: 1.0 - initial release
// ============================================================================
module ir_tx_scheduler
  import kfps2irkb_pkg::*;
#(
  parameter int          FIFO_AW       = 2,
  parameter logic [15:0] GAP_CYCLES    = GAP_CYCLES_DEF,
  parameter logic [15:0] START_TIMEOUT = START_TIMEOUT_DEF
) (
  input  wire logic        clock,
  input  wire logic        reset_n,
  ir_tx_scheduler_if.slave bus
);
  ir_sched_state_t      r_state;
  ir_sched_state_t      w_next;
  logic                 r_rr;
  logic [15:0]          r_tmo;
  logic [15:0]          r_gap;
  logic [KEYCODE_W-1:0] r_code;
  logic                 r_timeout;

  logic [1:0]           w_grant;
  logic                 w_push;
  logic [KEYCODE_W-1:0] w_din;
  logic [KEYCODE_W-1:0] w_head;
  logic                 w_full;
  logic                 w_empty;
  logic [FIFO_AW:0]     w_count;
  logic                 w_tx_start;
  logic                 w_pop;
  logic                 w_tmo_load;
  logic                 w_tmo_dec;
  logic                 w_gap_load;
  logic                 w_gap_dec;
  logic                 w_set_to;

  // Full blocks grants even when a pop happens in the same cycle.
  assign w_grant       = w_full ? 2'b00 : rr_grant(bus.req_valid, r_rr);
  assign w_push        = |w_grant;
  assign w_din         = w_grant[1] ? bus.req_code1 : bus.req_code0;
  assign bus.req_ready = w_grant;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr <= 1'b0;
    end else if (w_grant[0]) begin
      r_rr <= 1'b1;
    end else if (w_grant[1]) begin
      r_rr <= 1'b0;
    end
  end

  ir_code_fifo #(
    .FIFO_AW (FIFO_AW),
    .DW      (KEYCODE_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.fifo_count = w_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_tx_start = 1'b0;
    w_pop      = 1'b0;
    w_tmo_load = 1'b0;
    w_tmo_dec  = 1'b0;
    w_gap_load = 1'b0;
    w_gap_dec  = 1'b0;
    w_set_to   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) w_next = START;
      end
      START: begin
        w_tx_start = 1'b1;
        w_pop      = 1'b1;
        w_tmo_load = 1'b1;
        w_next     = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          w_next = WAIT_DONE;
        end else if (r_tmo == 16'd0) begin
          // The launched code is abandoned; scheduling carries on.
          w_set_to = 1'b1;
          w_next   = GAP;
        end else begin
          w_tmo_dec = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          w_gap_load = 1'b1;
          w_next     = GAP;
        end
      end
      GAP: begin
        if (r_gap == 16'd0) w_next = IDLE;
        else                w_gap_dec = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo     <= 16'd0;
      r_gap     <= 16'd0;
      r_code    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_tmo_load)     r_tmo <= START_TIMEOUT;
      else if (w_tmo_dec) r_tmo <= r_tmo - 16'd1;

      if (w_gap_load)     r_gap <= GAP_CYCLES;
      else if (w_gap_dec) r_gap <= r_gap - 16'd1;

      if (w_tx_start) r_code <= w_head;

      if (w_set_to)             r_timeout <= 1'b1;
      else if (bus.clear_error) r_timeout <= 1'b0;
    end
  end

  // Head is shown directly in START so the code is valid alongside the pulse.
  assign bus.tx_start   = w_tx_start;
  assign bus.tx_code    = (r_state == START) ? w_head : r_code;
  assign bus.tx_timeout = r_timeout;
endmodule
`default_nettype wire

// File: tb/tb_ir_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_ir_tx_scheduler
// Brief   : Scoreboard bench for ir_tx_scheduler with a serializer model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ir_tx_scheduler;
  localparam int GAP = 20;
  localparam int STO = 30;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  ir_tx_scheduler_if #(.FIFO_AW(2)) bus ();

  ir_tx_scheduler #(
    .FIFO_AW       (2),
    .GAP_CYCLES    (16'(GAP)),
    .START_TIMEOUT (16'(STO))
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int max_cnt = 0;
  int ser_len = 100;
  bit ser_never = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] src0[$];
  logic [7:0] src1[$];
  int acc_who[$];
  int acc_cyc[$];
  int start_log[$];
  int fall_log[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Serializer model: busy rises two cycles after tx_start, lasts ser_len cycles.
  initial begin
    int k;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n && bus.tx_start && !ser_never) begin
        k = 0;
        while (k < 2 && reset_n) begin @(negedge clock); k++; end
        if (reset_n) begin
          bus.tx_busy = 1'b1;
          k = 0;
          while (k < ser_len && reset_n) begin @(negedge clock); k++; end
        end
        bus.tx_busy = 1'b0;
      end
    end
  end

  // Monitor: pops the expected code on every launch.
  initial begin
    logic       prev_busy;
    logic [7:0] cur_code;
    prev_busy = 1'b0;
    cur_code  = 8'h00;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_busy = 1'b0;
      end else begin
        if (bus.tx_start) begin
          start_log.push_back(cyc);
          cur_code = bus.tx_code;
          if (exp_q.size() == 0) begin
            check("unexpected_start", 1, 0);
          end else begin
            check("tx_code", int'(bus.tx_code), int'(exp_q.pop_front()));
          end
        end
        if (bus.tx_busy) check("tx_code_stable", int'(bus.tx_code), int'(cur_code));
        if (prev_busy && !bus.tx_busy) fall_log.push_back(cyc);
        prev_busy = bus.tx_busy;
      end
    end
  end

  task automatic clear_logs();
    exp_q.delete(); src0.delete(); src1.delete();
    acc_who.delete(); acc_cyc.delete(); start_log.delete(); fall_log.delete();
    max_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    bus.req_valid = 2'b00;
    bus.clear_error = 1'b0;
    repeat (3) @(negedge clock);
    clear_logs();
    reset_n = 1'b1;
  endtask

  task automatic run_sources(input int budget);
    int n;
    n = 0;
    forever begin
      @(negedge clock);
      if (src0.size() == 0 && src1.size() == 0) begin
        bus.req_valid = 2'b00;
        break;
      end
      if (n >= budget) begin
        check("source_budget", n, budget - 1);
        bus.req_valid = 2'b00;
        src0.delete(); src1.delete();
        break;
      end
      bus.req_valid = {src1.size() != 0, src0.size() != 0};
      bus.req_code0 = (src0.size() != 0) ? src0[0] : 8'h00;
      bus.req_code1 = (src1.size() != 0) ? src1[0] : 8'h00;
      #1;
      if (bus.fifo_count == 3'd4) check("ready_when_full", int'(bus.req_ready), 0);
      if (int'(bus.fifo_count) > max_cnt) max_cnt = int'(bus.fifo_count);
      if (bus.req_valid[0] && bus.req_ready[0]) begin
        acc_who.push_back(0); acc_cyc.push_back(cyc); void'(src0.pop_front());
      end
      if (bus.req_valid[1] && bus.req_ready[1]) begin
        acc_who.push_back(1); acc_cyc.push_back(cyc); void'(src1.pop_front());
      end
      n++;
    end
  endtask

  // Waits until everything expected has launched and the scheduler sits quiet.
  task automatic wait_idle(input int budget);
    int n;
    int quiet;
    n = 0;
    quiet = 0;
    while (quiet < GAP + 10 && n < budget) begin
      @(negedge clock);
      n++;
      if (exp_q.size() == 0 && !bus.tx_busy && !bus.tx_start && bus.fifo_count == 3'd0)
        quiet++;
      else
        quiet = 0;
    end
    if (n >= budget) check("drain_budget", n, budget - 1);
  endtask

  initial begin
    int n;
    int t;
    int n_starts;
    int exp_who[4];
    exp_who = '{0, 1, 0, 1};
    bus.req_valid = 2'b00;
    bus.req_code0 = 8'h00;
    bus.req_code1 = 8'h00;
    bus.clear_error = 1'b0;

    // Reset values
    repeat (2) @(negedge clock);
    check("rst_tx_start", int'(bus.tx_start), 0);
    check("rst_tx_code", int'(bus.tx_code), 0);
    check("rst_fifo_count", int'(bus.fifo_count), 0);
    check("rst_tx_timeout", int'(bus.tx_timeout), 0);
    check("rst_req_ready", int'(bus.req_ready), 0);

    // Single requester: latency, code and gap after busy falls
    do_reset();
    ser_len = 100;
    src0.push_back(8'h1C); src0.push_back(8'h2A);
    exp_q.push_back(8'h1C); exp_q.push_back(8'h2A);
    run_sources(50);
    wait_idle(2000);
    check("t1_starts", start_log.size(), 2);
    check("t1_latency", start_log[0] - acc_cyc[0], 2);
    check("t1_gap_ok", int'(start_log[1] - fall_log[0] >= GAP + 1), 1);

    // Both requesters: round-robin alternation
    do_reset();
    ser_len = 20;
    src0.push_back(8'h1C); src0.push_back(8'h32);
    src1.push_back(8'hF0); src1.push_back(8'h1C);
    exp_q.push_back(8'h1C); exp_q.push_back(8'hF0);
    exp_q.push_back(8'h32); exp_q.push_back(8'h1C);
    run_sources(50);
    check("t2_accepts", acc_who.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t2_accept_order%0d", i), acc_who[i], exp_who[i]);
    wait_idle(2000);

    // Backpressure: FIFO saturates, last code waits for the next pop
    do_reset();
    ser_len = 60;
    for (int i = 0; i < 6; i++) begin
      src0.push_back(8'hA0 + 8'(i));
      exp_q.push_back(8'hA0 + 8'(i));
    end
    run_sources(400);
    check("t3_max_count", max_cnt, 4);
    check("t3_late_accept", acc_cyc[5] - start_log[1], 1);
    wait_idle(3000);
    check("t3_starts", start_log.size(), 6);

    // Start timeout, continuation and clear
    do_reset();
    ser_never = 1'b1;
    src0.push_back(8'h55); src0.push_back(8'h66);
    exp_q.push_back(8'h55); exp_q.push_back(8'h66);
    run_sources(20);
    n = 0;
    while (!bus.tx_timeout && n < 500) begin @(negedge clock); n++; end
    t = cyc;
    ser_never = 1'b0;
    check("t4_timeout_set", int'(bus.tx_timeout), 1);
    check("t4_timeout_lat", t - start_log[0], STO + 2);
    wait_idle(1000);
    check("t4_starts", start_log.size(), 2);
    check("t4_sticky", int'(bus.tx_timeout), 1);
    @(negedge clock); bus.clear_error = 1'b1;
    @(negedge clock); bus.clear_error = 1'b0;
    check("t4_cleared", int'(bus.tx_timeout), 0);

    // Asynchronous reset during WAIT_DONE with 3 queued
    do_reset();
    ser_len = 200;
    for (int i = 1; i <= 4; i++) begin
      src0.push_back(8'(i));
      exp_q.push_back(8'(i));
    end
    run_sources(20);
    n = 0;
    while (!bus.tx_busy && n < 50) begin @(negedge clock); n++; end
    repeat (4) @(negedge clock);
    check("t5_count_before", int'(bus.fifo_count), 3);
    #2 reset_n = 1'b0;
    #1;
    check("t5_tx_start", int'(bus.tx_start), 0);
    check("t5_tx_code", int'(bus.tx_code), 0);
    check("t5_fifo_count", int'(bus.fifo_count), 0);
    check("t5_req_ready", int'(bus.req_ready), 0);
    exp_q.delete();
    n_starts = start_log.size();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    check("t5_no_start", start_log.size(), n_starts);
    src0.push_back(8'h77); exp_q.push_back(8'h77);
    run_sources(20);
    wait_idle(1000);
    check("t5_new_start", start_log.size(), n_starts + 1);

    // Push and pop in the same cycle at count 2
    do_reset();
    ser_len = 10;
    src0.push_back(8'h11); src0.push_back(8'h22); src0.push_back(8'h33);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    run_sources(20);
    check("t6_count", int'(bus.fifo_count), 2);
    check("t6_pop_with_push", start_log[0], acc_cyc[2]);
    wait_idle(1000);
    check("t6_starts", start_log.size(), 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
